// File: rtl/mtc_thread_arbiter.sv
// Round-robin arbiter that merges per-thread ptcalc result FIFOs onto one
// registered valid/ready output lane, with per-thread drop accounting.
module mtc_thread_arbiter #(
  parameter int PTCALC_WIDTH  = 54,
  parameter int c_NUM_THREADS = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                                    clock,
  input  logic                                    rst_n,
  input  logic                                    srst,
  input  logic [c_NUM_THREADS-1:0]                ptcalc_valid,
  input  logic [PTCALC_WIDTH*c_NUM_THREADS-1:0]   ptcalc,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [PTCALC_WIDTH-1:0]                 out_data,
  output logic [$clog2(c_NUM_THREADS)-1:0]        out_thread,
  output logic [c_NUM_THREADS-1:0]                fifo_empty,
  output logic [c_NUM_THREADS-1:0]                overflow,
  output logic [CNT_WIDTH*c_NUM_THREADS-1:0]      overflow_cnt,
  output logic                                    idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(c_NUM_THREADS);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [PTCALC_WIDTH-1:0] head [c_NUM_THREADS];
  logic [c_NUM_THREADS-1:0] pop;

  logic                    out_valid_q,  out_valid_d;
  logic [PTCALC_WIDTH-1:0] out_data_q,   out_data_d;
  logic [TW-1:0]           out_thread_q, out_thread_d;
  logic [TW-1:0]           last_grant_q, last_grant_d;

  // Per-thread FIFO stage: write/drop decision, pointers, overflow accounting
  genvar g;
  for (g = 0; g < c_NUM_THREADS; g++) begin : g_thr
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic [PTCALC_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                    full;
    logic                    wr_en;
    logic                    drop;

    assign fifo_empty[g] = (wr_ptr_q == rd_ptr_q);
    assign full          = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                           (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A full FIFO still accepts when its head leaves at the same edge.
    always_comb begin
      wr_en    = ptcalc_valid[g] && (!full || pop[g]);
      drop     = ptcalc_valid[g] && !wr_en;
      wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, wr_en};
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop[g]};
      ovf_d    = ovf_q | drop;
      cnt_d    = drop ? sat_inc(cnt_q) : cnt_q;
    end

    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        ovf_q    <= 1'b0;
      end else if (srst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        ovf_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        ovf_q    <= ovf_d;
      end
    end

    always_ff @(posedge clock) begin
      if (wr_en) begin
        mem_q[wr_ptr_q[AW-1:0]] <= ptcalc[g*PTCALC_WIDTH +: PTCALC_WIDTH];
      end
    end

    assign head[g]                                = mem_q[rd_ptr_q[AW-1:0]];
    assign overflow[g]                            = ovf_q;
    assign overflow_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end

  logic          load;
  logic          found;
  logic [TW-1:0] winner;
  logic [TW-1:0] cand;

  // Grant stage: round-robin pick and output register update
  always_comb begin
    load         = (!out_valid_q || out_ready) && !(&fifo_empty);
    found        = 1'b0;
    winner       = '0;
    cand         = '0;
    pop          = '0;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_thread_d = out_thread_q;
    last_grant_d = last_grant_q;
    for (int i = 1; i <= c_NUM_THREADS; i++) begin
      cand = TW'((int'(last_grant_q) + i) % c_NUM_THREADS);
      if (!found && !fifo_empty[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    if (load) begin
      pop[winner]  = 1'b1;
      out_valid_d  = 1'b1;
      out_data_d   = head[winner];
      out_thread_d = winner;
      last_grant_d = winner;
    end else if (!out_valid_q || out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_thread_q <= '0;
      last_grant_q <= TW'(c_NUM_THREADS - 1);
    end else if (srst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_thread_q <= '0;
      last_grant_q <= TW'(c_NUM_THREADS - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_thread_q <= out_thread_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_thread = out_thread_q;
  assign idle       = (&fifo_empty) && !out_valid_q;

endmodule

// File: tb/tb_mtc_thread_arbiter.sv
// Randomised and directed bench for mtc_thread_arbiter: a queue-based reference
// model feeds an expected-word scoreboard drained by an independent monitor.
module tb_mtc_thread_arbiter;

  localparam int N    = 3;
  localparam int W    = 54;
  localparam int D    = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic             clock = 1'b0;
  logic             rst_n;
  logic             srst;
  logic [N-1:0]     ptcalc_valid;
  logic [W*N-1:0]   ptcalc;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [1:0]       out_thread;
  logic [N-1:0]     fifo_empty;
  logic [N-1:0]     overflow;
  logic [CW*N-1:0]  overflow_cnt;
  logic             idle;

  mtc_thread_arbiter #(.PTCALC_WIDTH(W), .c_NUM_THREADS(N), .FIFO_DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clock(clock), .rst_n(rst_n), .srst(srst), .ptcalc_valid(ptcalc_valid), .ptcalc(ptcalc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_thread(out_thread),
    .fifo_empty(fifo_empty), .overflow(overflow), .overflow_cnt(overflow_cnt), .idle(idle)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain per-thread queues plus the word held at the output.
  typedef struct { logic [W-1:0] d; int t; } exp_t;
  logic [W-1:0] mq [N][$];
  exp_t         exp_q[$];
  bit           m_hv;
  logic [W-1:0] m_hd;
  int           m_ht;
  int           m_last;
  bit [N-1:0]   m_ovf;
  int           m_cnt [N];
  bit           mon_en = 1'b0;

  task automatic model_reset();
    for (int t = 0; t < N; t++) begin
      mq[t].delete();
      m_cnt[t] = 0;
    end
    exp_q.delete();
    m_hv = 0; m_hd = '0; m_ht = 0; m_last = N - 1; m_ovf = '0;
  endtask

  task automatic model_step();
    int   w;
    int   c;
    exp_t e;
    w = -1;
    if (srst) begin
      model_reset();
      return;
    end
    if (!m_hv || out_ready) begin
      for (int i = 1; i <= N; i++) begin
        c = (m_last + i) % N;
        if (w < 0 && mq[c].size() > 0) w = c;
      end
    end
    if (w >= 0) begin
      m_hd = mq[w].pop_front();
      m_hv = 1; m_ht = w; m_last = w;
      e.d = m_hd; e.t = w;
      exp_q.push_back(e);
    end else if (!m_hv || out_ready) begin
      m_hv = 0;
    end
    for (int t = 0; t < N; t++) begin
      if (ptcalc_valid[t]) begin
        if (mq[t].size() < D) mq[t].push_back(ptcalc[t*W +: W]);
        else begin
          m_ovf[t] = 1'b1;
          if (m_cnt[t] < CMAX) m_cnt[t]++;
        end
      end
    end
  endtask

  function automatic logic [N-1:0] m_empty();
    logic [N-1:0] e;
    for (int t = 0; t < N; t++) e[t] = (mq[t].size() == 0);
    return e;
  endfunction

  function automatic logic [CW*N-1:0] m_cntv();
    logic [CW*N-1:0] v;
    for (int t = 0; t < N; t++) v[t*CW +: CW] = CW'(m_cnt[t]);
    return v;
  endfunction

  // Monitor: compares the presented word against the scoreboard head.
  always @(negedge clock) begin
    if (mon_en && rst_n) begin
      check("out_valid", 64'(out_valid), 64'(m_hv));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL out_word: got %0h thread %0d expected no word", out_data, out_thread);
        end else begin
          check("out_data", 64'(out_data), 64'(exp_q[0].d));
          check("out_thread", 64'(out_thread), 64'(exp_q[0].t));
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("out_data_hold", 64'(out_data), 64'(m_hd));
      end
      check("fifo_empty", 64'(fifo_empty), 64'(m_empty()));
      check("idle", 64'(idle), 64'((&m_empty()) && !m_hv));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("overflow_cnt", 64'(overflow_cnt), 64'(m_cntv()));
    end
  end

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic rdy);
    ptcalc_valid = v;
    out_ready    = rdy;
    for (int t = 0; t < N; t++) ptcalc[t*W +: W] = W'({$urandom(), $urandom()});
  endtask

  int saved_cnt;

  initial begin
    rst_n = 1'b0; srst = 1'b0; ptcalc_valid = '0; ptcalc = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_fifo_empty", 64'(fifo_empty), 64'h7);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    mon_en = 1'b1;

    // Single word from thread 1
    drive(3'b010, 1'b1);
    ptcalc[1*W +: W] = 54'h1234;
    cycle();
    check("lat_not_yet", 64'(out_valid), 64'd0);
    drive(3'b000, 1'b1);
    cycle();
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_data", 64'(out_data), 64'h1234);
    check("single_thread", 64'(out_thread), 64'd1);
    cycle();
    check("single_gone", 64'(out_valid), 64'd0);

    // Fairness: all threads for 4 cycles
    for (int i = 0; i < 4; i++) begin drive(3'b111, 1'b1); cycle(); end
    drive(3'b000, 1'b1);
    repeat (14) cycle();
    check("fair_no_ovf", 64'(overflow), 64'd0);

    // Backpressure on thread 2
    for (int i = 0; i < 10; i++) begin drive((i < 6) ? 3'b100 : 3'b000, 1'b0); cycle(); end
    check("bp_ovf2", 64'(overflow[2]), 64'd1);
    drive(3'b000, 1'b1);
    repeat (8) cycle();

    // Full FIFO 0 with a simultaneous pop
    for (int i = 0; i < 5; i++) begin drive(3'b001, 1'b0); cycle(); end
    check("full0", 64'(m_empty()[0] == 1'b0 && mq[0].size() == D), 64'd1);
    saved_cnt = m_cnt[0];
    drive(3'b001, 1'b1);
    cycle();
    check("full_pop_cnt0", 64'(overflow_cnt[CW-1:0]), 64'(saved_cnt));
    drive(3'b000, 1'b1);
    repeat (8) cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(N'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7));
      cycle();
    end
    drive(3'b000, 1'b1);
    repeat (20) cycle();

    // Counter saturation on thread 0
    for (int i = 0; i < 310; i++) begin drive(3'b001, 1'b0); cycle(); end
    check("sat_cnt0", 64'(overflow_cnt[CW-1:0]), 64'd255);

    // Soft reset
    drive(3'b000, 1'b0);
    srst = 1'b1;
    cycle();
    srst = 1'b0;
    check("srst_cnt", 64'(overflow_cnt), 64'd0);
    check("srst_ovf", 64'(overflow), 64'd0);
    check("srst_empty", 64'(fifo_empty), 64'h7);
    drive(3'b111, 1'b1);
    cycle();
    drive(3'b000, 1'b1);
    cycle();
    check("srst_first_grant", 64'(out_thread), 64'd0);
    repeat (4) cycle();

    // Asynchronous reset while a word is held and FIFOs are occupied
    drive(3'b011, 1'b0);
    cycle();
    cycle();
    drive(3'b000, 1'b0);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_data", 64'(out_data), 64'd0);
    check("arst_thread", 64'(out_thread), 64'd0);
    model_reset();
    @(negedge clock);
    #2;
    rst_n = 1'b1;
    #1;
    check("arst_idle", 64'(idle), 64'd1);
    check("arst_empty", 64'(fifo_empty), 64'h7);
    cycle();
    mon_en = 1'b1;
    drive(3'b100, 1'b1);
    cycle();
    drive(3'b000, 1'b1);
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
